// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Central sequencer for the 5-stage OTTER pipeline. Produces the PC write
//   enable and the load enables / flush controls of the IF/DE, DE/EX, EX/MEM
//   and MEM/WB registers. It detects read-after-write hazards between the
//   instruction in decode and older instructions still in flight, and it
//   freezes the whole pipeline while data memory is busy. It applies
//   decode-resolved branch/jump redirects and runs the interrupt
//   drain-and-take state machine.
//
// Build option:
//   FORWARDING_EN  When defined, execute/memory forwarding exists in the
//                  datapath, so only a load-use pair stalls (one cycle).
//                  When undefined, any RAW dependency on EXE/MEM/WB stalls
//                  until the writer retires.
//
// Parameters:
//   DRAIN_MAX   Drain watchdog: forced interrupt take after this many
//               non-busy drain cycles (5-bit counter).
//
// Ports:
//   clk                         clock, all state on rising edge
//   rst_n                       synchronous active-low reset
//   dec_ir/exe_ir/mem_ir/wb_ir  stage instruction registers
//   exe_valid/mem_valid/wb_valid stage holds a real instruction
//   dec_clear                   taken branch/jump resolved in decode
//   mem_busy                    data memory not ready, MEM must hold
//   intr                        external interrupt request (level)
//   csr_mie                     global interrupt enable
//   pc_we                       PC write enable
//   if_de_en/de_ex_en/ex_mem_en/mem_wb_en  pipeline register load enables
//   if_flush                    load NOP into IF/DE
//   de_bubble                   load bubble into DE/EX
//   int_taken                   one-cycle pulse: vector to mtvec, save mepc
//   state                       FSM state (0 RUN, 1 MEM_WAIT, 2 INT_DRAIN,
//                               3 INT_TAKE)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dec_ir,
  input  logic [31:0] exe_ir,
  input  logic [31:0] mem_ir,
  input  logic [31:0] wb_ir,
  input  logic        exe_valid,
  input  logic        mem_valid,
  input  logic        wb_valid,
  input  logic        dec_clear,
  input  logic        mem_busy,
  input  logic        intr,
  input  logic        csr_mie,
  output logic        pc_we,
  output logic        if_de_en,
  output logic        de_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        if_flush,
  output logic        de_bubble,
  output logic        int_taken,
  output logic [1:0]  state
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT  = 2'd1;
  localparam logic [1:0] ST_INT_DRAIN = 2'd2;
  localparam logic [1:0] ST_INT_TAKE  = 2'd3;

  localparam int CNT_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ---------------------------------------------------------------------------
  // Operand-usage decode
  // ---------------------------------------------------------------------------
  function automatic logic uses_rs1(input logic [31:0] ir);
    logic r;
    r = 1'b0;
    case (ir[6:0])
      OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: r = 1'b1;
      OPC_SYSTEM: r = (ir[14:12] != 3'd0);
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    logic r;
    r = 1'b0;
    case (ir[6:0])
      OPC_BRANCH, OPC_STORE, OPC_OP: r = 1'b1;
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic writes_rd(input logic [31:0] ir);
    logic r;
    r = 1'b0;
    case (ir[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP: r = 1'b1;
      OPC_SYSTEM: r = (ir[14:12] == 3'd1);
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // RAW detection against the three producer stages (0 EXE, 1 MEM, 2 WB)
  // ---------------------------------------------------------------------------
  logic [31:0] prod_ir    [3];
  logic [2:0]  prod_valid;
  logic [2:0]  raw;
  logic        dec_use1;
  logic        dec_use2;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        haz;

  assign prod_ir[0]  = exe_ir;
  assign prod_ir[1]  = mem_ir;
  assign prod_ir[2]  = wb_ir;
  assign prod_valid  = {wb_valid, mem_valid, exe_valid};

  assign dec_use1 = uses_rs1(dec_ir);
  assign dec_use2 = uses_rs2(dec_ir);
  assign dec_rs1  = dec_ir[19:15];
  assign dec_rs2  = dec_ir[24:20];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_raw
      logic [4:0] rd;
      assign rd = prod_ir[gi][11:7];
      // x0 is hard-wired, so a write to it can never create a dependency.
      assign raw[gi] = prod_valid[gi] & writes_rd(prod_ir[gi]) & (rd != 5'd0) &
                       ((dec_use1 & (rd == dec_rs1)) | (dec_use2 & (rd == dec_rs2)));
    end
  endgenerate

`ifdef FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time; everything else bypasses.
  assign haz = raw[0] & (exe_ir[6:0] == OPC_LOAD);
`else
  assign haz = |raw;
`endif

  // Bits not consumed by the decode above.
  logic unused_ir_bits;
  assign unused_ir_bits = ^{dec_ir[31:25], dec_ir[11:7]};

  // ---------------------------------------------------------------------------
  // FSM and drain watchdog
  // ---------------------------------------------------------------------------
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] drain_cnt_reg;
  logic [CNT_W-1:0] drain_cnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_RUN;
      drain_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
    end
  end

  assign state = state_reg;

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    pc_we          = 1'b0;
    if_de_en       = 1'b0;
    de_ex_en       = 1'b0;
    ex_mem_en      = 1'b0;
    mem_wb_en      = 1'b0;
    if_flush       = 1'b0;
    de_bubble      = 1'b0;
    int_taken      = 1'b0;

    case (state_reg)
      // MEM_WAIT releases into a cycle that is evaluated exactly like RUN.
      ST_RUN, ST_MEM_WAIT: begin
        if (mem_busy) begin
          state_next = ST_MEM_WAIT;
        end else if (haz) begin
          // Hold fetch/decode, push a bubble, let older instructions advance.
          // A redirect in this cycle is dropped: its operands are stale.
          state_next = ST_RUN;
          de_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          mem_wb_en  = 1'b1;
          de_bubble  = 1'b1;
        end else begin
          pc_we     = 1'b1;
          if_de_en  = 1'b1;
          de_ex_en  = 1'b1;
          ex_mem_en = 1'b1;
          mem_wb_en = 1'b1;
          if (dec_clear) begin
            if_flush   = 1'b1;
            de_bubble  = 1'b1;
            state_next = ST_RUN;
          end else if (intr && csr_mie) begin
            state_next = ST_INT_DRAIN;
          end else begin
            state_next = ST_RUN;
          end
        end
      end

      ST_INT_DRAIN: begin
        // Front end frozen, bubbles injected; downstream empties out.
        de_bubble = 1'b1;
        if (!mem_busy) begin
          de_ex_en       = 1'b1;
          ex_mem_en      = 1'b1;
          mem_wb_en      = 1'b1;
          drain_cnt_next = drain_cnt_reg + 1'b1;
          if (!(exe_valid || mem_valid || wb_valid) ||
              (drain_cnt_reg == CNT_W'(DRAIN_MAX - 1))) begin
            state_next = ST_INT_TAKE;
          end
        end
      end

      default: begin // ST_INT_TAKE
        pc_we          = 1'b1;
        if_de_en       = 1'b1;
        de_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        if_flush       = 1'b1;
        de_bubble      = 1'b1;
        int_taken      = 1'b1;
        drain_cnt_next = '0;
        state_next     = ST_RUN;
      end
    endcase

    // While reset is held the pipeline is flushed with everything enabled.
    if (!rst_n) begin
      pc_we     = 1'b1;
      if_de_en  = 1'b1;
      de_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if_flush  = 1'b1;
      de_bubble = 1'b1;
      int_taken = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl. A behavioural model (output
// table per situation plus a mode/cycle-count tracker) predicts every output
// each cycle. Directed scenarios move a small pipeline model so stall, freeze
// and interrupt sequences play out; a random phase follows.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int DRAIN_MAX = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dec_ir, exe_ir, mem_ir, wb_ir;
  logic        exe_valid, mem_valid, wb_valid;
  logic        dec_clear, mem_busy, intr, csr_mie;
  logic        pc_we, if_de_en, de_ex_en, ex_mem_en, mem_wb_en;
  logic        if_flush, de_bubble, int_taken;
  logic [1:0]  state;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_ir(dec_ir), .exe_ir(exe_ir), .mem_ir(mem_ir), .wb_ir(wb_ir),
    .exe_valid(exe_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .dec_clear(dec_clear), .mem_busy(mem_busy), .intr(intr), .csr_mie(csr_mie),
    .pc_we(pc_we), .if_de_en(if_de_en), .de_ex_en(de_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_flush(if_flush),
    .de_bubble(de_bubble), .int_taken(int_taken), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Mode: -1 unknown, 0 running, 1 waiting on memory, 2 draining, 3 taking.
  int m_mode   = -1;
  int m_drains = 0;   // non-busy drain cycles already spent
  logic [7:0] last_exp;  // {pc_we,if_de,de_ex,ex_mem,mem_wb,flush,bubble,taken}
  logic [9:0] obs;       // DUT outputs plus state, sampled this cycle

  function automatic bit m_reads1(input logic [31:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return (o inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33}) ||
           (o == 7'h73 && ir[14:12] != 3'd0);
  endfunction

  function automatic bit m_reads2(input logic [31:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return o inside {7'h63, 7'h23, 7'h33};
  endfunction

  function automatic bit m_writes(input logic [31:0] ir);
    logic [6:0] o;
    o = ir[6:0];
    return (o inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33}) ||
           (o == 7'h73 && ir[14:12] == 3'd1);
  endfunction

  function automatic bit m_hazard();
    logic [31:0] irs [3];
    bit          vs  [3];
    logic [4:0]  rd;
    bit          h;
    irs = '{exe_ir, mem_ir, wb_ir};
    vs  = '{exe_valid, mem_valid, wb_valid};
    h   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = irs[i][11:7];
      if (vs[i] && m_writes(irs[i]) && rd != 5'd0 &&
          ((m_reads1(dec_ir) && rd == dec_ir[19:15]) ||
           (m_reads2(dec_ir) && rd == dec_ir[24:20]))) begin
`ifdef FORWARDING_EN
        if (i == 0 && irs[0][6:0] == 7'h03) h = 1'b1;
`else
        h = 1'b1;
`endif
      end
    end
    return h;
  endfunction

  // One clock: inputs already driven (at negedge); check outputs, advance.
  task automatic cycle(input string tag);
    logic [7:0] e;
    int nxt, ndr;
    #2;
    nxt = m_mode;
    ndr = m_drains;
    if (!rst_n) begin
      e = 8'b1111_1110; nxt = 0; ndr = 0;
    end else begin
      case (m_mode)
        0, 1: begin
          if (mem_busy)       begin e = 8'b0000_0000; nxt = 1; end
          else if (m_hazard()) begin e = 8'b0011_1010; nxt = 0; end
          else if (dec_clear) begin e = 8'b1111_1110; nxt = 0; end
          else begin
            e   = 8'b1111_1000;
            nxt = (intr && csr_mie) ? 2 : 0;
          end
        end
        2: begin
          if (mem_busy) e = 8'b0000_0010;
          else begin
            e   = 8'b0011_1010;
            ndr = m_drains + 1;
            if (!(exe_valid || mem_valid || wb_valid) || m_drains == DRAIN_MAX - 1)
              nxt = 3;
          end
        end
        3: begin e = 8'b1111_1111; nxt = 0; ndr = 0; end
        default: e = 8'bx;
      endcase
    end
    obs      = {pc_we, if_de_en, de_ex_en, ex_mem_en, mem_wb_en,
                if_flush, de_bubble, int_taken, state};
    last_exp = e;
    if (m_mode >= 0 || !rst_n) check({tag, "_outs"}, {24'd0, obs[9:2]}, {24'd0, e});
    if (m_mode >= 0)           check({tag, "_state"}, {30'd0, obs[1:0]}, m_mode);
    @(posedge clk);
    m_mode   = nxt;
    m_drains = ndr;
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Tiny pipeline model driven by the predicted controls
  // ---------------------------------------------------------------------------
  task automatic pipe_init();
    dec_ir = NOP; exe_ir = NOP; mem_ir = NOP; wb_ir = NOP;
    exe_valid = 1'b1; mem_valid = 1'b1; wb_valid = 1'b1;
    dec_clear = 1'b0; mem_busy = 1'b0; intr = 1'b0; csr_mie = 1'b0;
  endtask

  task automatic pipe_step(input string tag);
    logic [7:0] e;
    cycle(tag);
    e = last_exp;
    if (e[3]) begin wb_ir = mem_ir; wb_valid = mem_valid; end
    if (e[4]) begin mem_ir = exe_ir; mem_valid = exe_valid; end
    if (e[5]) begin exe_ir = e[1] ? NOP : dec_ir; exe_valid = !e[1]; end
    if (e[6]) dec_ir = NOP;
    dec_clear = 1'b0;
  endtask

  // Run until PC advances again; return number of stalled cycles.
  task automatic count_stalls(input string tag, output int stalls);
    stalls = 0;
    for (int i = 0; i < 8; i++) begin
      pipe_step(tag);
      if (obs[9]) break;
      stalls++;
    end
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] opcs [11];
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0f};
    return {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
            opcs[$urandom_range(0, 10)]};
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int stalls, cnt, pulses;
    logic [31:0] lw_x5, add_x6_x5, addi_x0, add_x6_x0;
    lw_x5     = {12'd0, 5'd1, 3'd2, 5'd5, 7'h03};
    add_x6_x5 = {7'd0, 5'd5, 5'd5, 3'd0, 5'd6, 7'h33};
    addi_x0   = {12'd1, 5'd0, 3'd0, 5'd0, 7'h13};
    add_x6_x0 = {7'd0, 5'd0, 5'd0, 3'd0, 5'd6, 7'h33};

    pipe_init();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset held two cycles, then first running cycle.
    cycle("rst0");
    cycle("rst1");
    rst_n = 1'b1;
    cycle("post_rst");
    check("post_rst_state", {30'd0, obs[1:0]}, 0);
    check("post_rst_en", {27'd0, obs[9:5]}, 5'b11111);
    check("post_rst_taken", {31'd0, obs[2]}, 0);
    $display("[TB] reset sequence done");

    // RAW stall on a load producer.
    pipe_init();
    dec_ir = add_x6_x5; exe_ir = lw_x5;
    count_stalls("raw_lw", stalls);
`ifdef FORWARDING_EN
    check("raw_lw_stalls", stalls, 1);
`else
    check("raw_lw_stalls", stalls, 3);
`endif
    $display("[TB] load-use stall: %0d cycles", stalls);

    // Producer writing x0 never stalls.
    pipe_init();
    dec_ir = add_x6_x0; exe_ir = addi_x0;
    count_stalls("raw_x0", stalls);
    check("raw_x0_stalls", stalls, 0);
    $display("[TB] x0 producer: %0d stall cycles", stalls);

    // Redirect without hazard flushes; with hazard it is ignored.
    pipe_init();
    dec_clear = 1'b1;
    pipe_step("clr");
    check("clr_flush", {29'd0, obs[9], obs[4:3]}, 3'b111);
    pipe_init();
    dec_ir = add_x6_x5; exe_ir = lw_x5; dec_clear = 1'b1;
    pipe_step("clr_haz");
    check("clr_haz_flush", {29'd0, obs[9], obs[4:3]}, 3'b001);
    $display("[TB] redirect checks done");

    // Memory busy for four cycles freezes everything, then resumes.
    pipe_init();
    mem_busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      pipe_step("busy");
      if (obs[9:5] == 5'b00000) cnt++;
    end
    check("busy_frozen_cycles", cnt, 4);
    mem_busy = 1'b0;
    pipe_step("busy_release");
    check("busy_release_en", {27'd0, obs[9:5]}, 5'b11111);
    check("busy_release_state", {30'd0, obs[1:0]}, 1);
    pipe_step("busy_after");
    $display("[TB] memory freeze: %0d cycles", cnt);

    // Interrupt with a full pipeline; request drops during the drain.
    pipe_init();
    intr = 1'b1; csr_mie = 1'b1;
    pipe_step("int_entry");
    intr = 1'b0;
    pulses = 0;
    for (int i = 0; i < 30 && pulses == 0; i++) begin
      pipe_step("int_drain");
      if (obs[2]) pulses++;
    end
    check("int_pulses", pulses, 1);
    pipe_step("int_after");
    check("int_after_state", {30'd0, obs[1:0]}, 0);
    check("int_after_taken", {31'd0, obs[2]}, 0);
    $display("[TB] interrupt take: %0d pulse(s)", pulses);

    // Stuck EXE valid: watchdog forces the take.
    pipe_init();
    intr = 1'b1; csr_mie = 1'b1;
    pipe_step("wd_entry");
    intr = 1'b0;
    cnt = 0; pulses = 0;
    for (int i = 0; i < 40 && pulses == 0; i++) begin
      pipe_step("wd_drain");
      exe_valid = 1'b1;
      if (obs[1:0] == 2'd2) cnt++;
      if (obs[2]) pulses++;
    end
    check("wd_drain_cycles", cnt, DRAIN_MAX);
    check("wd_pulses", pulses, 1);
    pipe_step("wd_after");
    $display("[TB] watchdog drain: %0d cycles", cnt);

    // Reset in the middle of a drain: no take pulse.
    pipe_init();
    intr = 1'b1; csr_mie = 1'b1;
    pipe_step("rst_mid_entry");
    pipe_step("rst_mid_drain");
    rst_n = 1'b0;
    pipe_step("rst_mid_rst");
    rst_n = 1'b1; intr = 1'b0;
    pipe_step("rst_mid_after");
    check("rst_mid_state", {30'd0, obs[1:0]}, 0);
    check("rst_mid_taken", {31'd0, obs[2]}, 0);
    $display("[TB] reset mid-drain done");

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      rst_n     = ($urandom_range(0, 49) != 0);
      dec_ir    = rand_ir();
      exe_ir    = rand_ir();
      mem_ir    = rand_ir();
      wb_ir     = rand_ir();
      exe_valid = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      wb_valid  = 1'($urandom_range(0, 1));
      dec_clear = ($urandom_range(0, 6) == 0);
      mem_busy  = ($urandom_range(0, 6) == 0);
      intr      = ($urandom_range(0, 2) == 0);
      csr_mie   = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end
    $display("[TB] random phase: 3000 cycles");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
